rom_fetch_ctrl: RTL
===================

// Module: rom_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the combinational program memory (rom).
//  - Owns the fetch PC and drives the rom word address every cycle.
//  - Buffers fetched words with their PC in a small prefetch FIFO.
//  - Hands words to decode over a valid/ready handshake.
//  - Handles branch redirects (flush) and halt.
//  Sits between rom and the CPU decode stage.
// PARAMETERS
//  DATA_WIDTH  32   instruction word width; must match rom.
//  ADDR_WIDTH  27   rom word-address width; the PC counts words.
//  RESET_PC    0    fetch PC loaded on reset.
//  FIFO_DEPTH  2    prefetch entries; power of 2, >=2.
// PORTS
//  clk            in   1           rising-edge clock.
//  reset          in   1           asynchronous, active-high reset.
//  rom_addr       out  ADDR_WIDTH  to rom address; equals fpc (combinational from register).
//  rom_data       in   DATA_WIDTH  rom data; valid in the same cycle as rom_addr.
//  redirect_valid in   1           branch/jump taken; flush and refetch.
//  redirect_pc    in   ADDR_WIDTH  new fetch PC, sampled when redirect_valid=1.
//  halt           in   1           level; stop issuing fetches while high.
//  inst_valid     out  1           head entry valid.
//  inst_ready     in   1           decode accepts head.
//  inst_data      out  DATA_WIDTH  instruction word of head.
//  inst_pc        out  ADDR_WIDTH  PC of head.
//  idle           out  1           state==HALT and FIFO empty.
// BEHAVIOUR
//  - Reset: fpc=RESET_PC, FIFO empty, state=RUN, inst_valid=0,
//    inst_data=0, inst_pc=0, idle=0. Reset mid-operation drops all entries immediately.
//  - States:
//    - RUN: push {fpc, rom_data} and fpc<=fpc+1 when push_ok,
//      where push_ok = !full || (inst_valid && inst_ready).
//    - RUN->HALT when halt=1; no push occurs in that cycle.
//    - HALT: no push; fpc holds; FIFO keeps draining.
//    - HALT->RUN when halt=0; push resumes the next cycle.
//  - Pop: occurs when inst_valid && inst_ready.
//    - Simultaneous push and pop is allowed when full.
//  - Fetch-to-inst_valid latency: 1 cycle (word is registered in the FIFO).
//  - inst_data and inst_pc are stable while inst_valid=1 && inst_ready=0.
//  - Redirect (priority over push and over halt):
//    - FIFO flushed; fpc<=redirect_pc; no push that cycle.
//    - A pop in the same cycle still completes; the word is consumed.
//    - The first post-redirect word is visible 2 cycles after the redirect cycle.
//    - State is unchanged.
//  - fpc arithmetic is modulo 2^ADDR_WIDTH: all-ones wraps to 0.
// CONFIGURATION
//  ROM_FETCH_BYPASS_EN
//  - Defined:
//    - When FIFO empty, state RUN and no redirect: inst_valid=1, inst_data=rom_data
//      and inst_pc=fpc combinationally (0-cycle latency).
//    - If accepted: fpc advances and no push.
//    - If not accepted: normal push.
//  - Undefined: inst_* outputs come only from the FIFO head (1-cycle latency).
// STRUCTURE
//  - Package rom_fetch_pkg:
//    - fetch_state_e {RUN, HALT}.
//    - fetch_entry_t {pc, data}.
//    - Localparam for FIFO pointer width = $clog2(FIFO_DEPTH)+1.
//  - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with
//    push/pop/flush and full/empty. Same-cycle flush+push: flush wins.
//  - Top: fpc register, state FSM, push/pop/flush logic, optional bypass mux.
// TESTING
//  1. Reset with RESET_PC=4, rom[n]=n, inst_ready=1:
//     inst_valid rises in cycle 1; pc/data sequence 4,5,6... one per cycle.
//  2. inst_ready=0 for 5 cycles:
//     FIFO fills to 2; rom_addr holds at 6; inst_data stays 4;
//     on release, 4,5,6 are delivered with no gap or duplicate.
//  3. redirect_valid with redirect_pc=100 while the head at pc 7 is accepted:
//     7 is consumed; the next delivered pc is 100, two cycles later.
//  4. halt=1 for 4 cycles:
//     FIFO drains, idle=1, rom_addr frozen;
//     halt=0 resumes at the frozen PC. Redirect during halt updates fpc only.
//  5. redirect_pc=2^27-1:
//     delivered pcs are 134217727 then 0.
//  6. Bypass: with ROM_FETCH_BYPASS_EN defined, redirect to pc 8 with inst_ready=1:
//     pc 8 is delivered 1 cycle after the redirect cycle;
//     without the macro, it is delivered 2 cycles after.

Source files
------------

// File: rtl/rom_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_pkg
// Description : Shared types and constants for the rom fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_fetch_pkg;

    localparam int C_ADDR_WIDTH      = 27;
    localparam int C_DATA_WIDTH      = 32;
    localparam int C_FIFO_DEPTH      = 2;
    localparam int C_FIFO_PTR_WIDTH  = $clog2(C_FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [C_ADDR_WIDTH-1:0] pc;
        logic [C_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

    // Extra MSB distinguishes full from empty when the index bits match.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_fetch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch FIFO of fetch_entry_t with push/pop/flush.
//               A flush in the same cycle as a push discards the push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter int DEPTH = C_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head_entry,
    output logic         o_full,
    output logic         o_empty
);

    localparam int C_PW = fifo_ptr_width(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [C_PW-1:0] wr_ptr_q;
    logic [C_PW-1:0] wr_ptr_d;
    logic [C_PW-1:0] rd_ptr_q;
    logic [C_PW-1:0] rd_ptr_d;
    logic [C_PW-2:0] w_wr_idx;
    logic [C_PW-2:0] w_rd_idx;

    assign w_wr_idx     = wr_ptr_q[C_PW-2:0];
    assign w_rd_idx     = rd_ptr_q[C_PW-2:0];
    assign o_empty      = (wr_ptr_q == rd_ptr_q);
    assign o_full       = (wr_ptr_q[C_PW-1] != rd_ptr_q[C_PW-1]) && (w_wr_idx == w_rd_idx);
    assign o_head_entry = mem_q[w_rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + C_PW'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + C_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (i_push && !i_flush) begin
                mem_q[w_wr_idx] <= i_push_entry;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_ctrl
// Description : Instruction-fetch sequencer between the combinational rom and
//               decode: fetch PC, prefetch FIFO, redirect flush and halt.
//               Optional macro ROM_FETCH_BYPASS_EN enables a 0-latency path
//               from rom_data to inst_* when the FIFO is empty.
//               DATA_WIDTH/ADDR_WIDTH must equal the package entry widths.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = C_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = C_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = C_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  idle
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] fpc_q;
    logic [ADDR_WIDTH-1:0] fpc_d;

    fetch_entry_t w_push_entry;
    fetch_entry_t w_head_entry;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_fifo_pop;
    logic         w_push_ok;
    logic         w_push;
    logic         w_bypass;
    logic         w_bypass_take;

    assign rom_addr = fpc_q;
    assign idle     = (state_q == HALT) && w_fifo_empty;

`ifdef ROM_FETCH_BYPASS_EN
    assign w_bypass = w_fifo_empty && (state_q == RUN) && !redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_pop    = !w_fifo_empty && inst_ready;
    assign w_bypass_take = w_bypass && inst_ready;
    assign w_push_ok     = !w_fifo_full || w_fifo_pop;
    // A redirect or an accepted bypass word both suppress the FIFO write.
    assign w_push        = (state_q == RUN) && !halt && !redirect_valid
                           && w_push_ok && !w_bypass_take;

    always_comb begin
        w_push_entry.pc   = fpc_q;
        w_push_entry.data = rom_data;
    end

    always_comb begin
        inst_valid = !w_fifo_empty;
        inst_data  = w_head_entry.data;
        inst_pc    = w_head_entry.pc;
        if (w_bypass) begin
            inst_valid = 1'b1;
            inst_data  = rom_data;
            inst_pc    = fpc_q;
        end
    end

    always_comb begin
        fpc_d   = fpc_q;
        state_d = state_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc;
        end else begin
            state_d = halt ? HALT : RUN;
            if (w_push || w_bypass_take) begin
                fpc_d = fpc_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_fifo_pop),
        .i_flush      (redirect_valid),
        .o_head_entry (w_head_entry),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

endmodule
`default_nettype wire
